multicycle_controller: RTL and testbench

Control FSM that sequences a multi-cycle implementation of the team's MIPS datapath. It drives one shared memory for both instruction fetch and data, plus the register file, ALU and PC. It supports R-format add/sub, lw, sw and beq. Memory accesses use a ready handshake, and the block exposes retired-instruction and halt/fault status for the testbench.

---
 rtl/multicycle_controller.sv | 209 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle MIPS datapath: sequences fetch, decode, execute,
// memory and write-back over a shared ready-handshaked memory, with halt/fault status.
module multicycle_controller #(
  parameter int COUNT_W    = 32,
  parameter int WAIT_LIMIT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         op_code,
  input  logic               zero_flag,
  input  logic               mem_ready,
  output logic               mem_read,
  output logic               mem_write,
  output logic               iord,
  output logic               ir_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               pc_en,
  output logic [3:0]         state,
  output logic [COUNT_W-1:0] instr_count,
  output logic               halted,
  output logic               illegal_op,
  output logic               mem_timeout
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_HALT      = 4'd9
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  // Counter just wide enough to hold WAIT_LIMIT itself.
  localparam int WAIT_W = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_LIMIT);

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               illegal_q, illegal_d;
  logic               timeout_q, timeout_d;

  logic pc_write;
  logic pc_write_cond;
  logic wait_expired;
  logic set_illegal;
  logic set_timeout;
  logic mem_state;
  logic retire;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    set_illegal   = 1'b0;
    set_timeout   = 1'b0;
    mem_state     = 1'b0;

    // A completing access (mem_ready=1) always wins over an expiring wait.
    wait_expired = (WAIT_LIMIT != 0) && (wait_q == WAIT_MAX) && !mem_ready;

    case (state_q)
      S_FETCH: begin
        mem_state = 1'b1;
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (wait_expired) begin
          state_d     = S_HALT;
          set_timeout = 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (op_code)
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          default: begin
            state_d     = S_HALT;
            set_illegal = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (op_code == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_state = 1'b1;
        mem_read  = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (wait_expired) begin
          state_d     = S_HALT;
          set_timeout = 1'b1;
        end
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_state = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (wait_expired) begin
          state_d     = S_HALT;
          set_timeout = 1'b1;
        end
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        state_d       = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    pc_en = pc_write | (pc_write_cond & zero_flag);

    // Counter only runs while stalled in the same memory state; any entry or exit clears it.
    if (mem_state && (state_d == state_q) && !mem_ready) begin
      wait_d = wait_q + 1'b1;
    end else begin
      wait_d = '0;
    end

    retire = (state_d == S_FETCH) &&
             ((state_q == S_MEM_WB) || (state_q == S_MEM_WRITE) ||
              (state_q == S_R_WB)   || (state_q == S_BRANCH));
    count_d   = retire ? count_q + COUNT_W'(1) : count_q;
    illegal_d = illegal_q | set_illegal;
    timeout_d = timeout_q | set_timeout;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign state       = state_q;
  assign instr_count = count_q;
  assign halted      = (state_q == S_HALT);
  assign illegal_op  = illegal_q;
  assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: expected values are queued as stimulus
// is applied and popped when the corresponding DUT outputs are sampled.
module tb_multicycle_controller;

  localparam int COUNT_W    = 32;
  localparam int WAIT_LIMIT = 8;

  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_READ = 4'd3,
                         MEM_WB = 4'd4, MEM_WRITE = 4'd5, EXECUTE = 4'd6, R_WB = 4'd7,
                         BRANCH = 4'd8, HALT = 4'd9;

  logic               clk;
  logic               rst_n;
  logic [5:0]         op_code;
  logic               zero_flag;
  logic               mem_ready;
  logic               mem_read, mem_write, iord, ir_write, reg_write, reg_dst, mem_to_reg;
  logic               alu_src_a;
  logic [1:0]         alu_src_b, alu_op, pc_source;
  logic               pc_en;
  logic [3:0]         state;
  logic [COUNT_W-1:0] instr_count;
  logic               halted, illegal_op, mem_timeout;
  logic [14:0]        ctl;

  multicycle_controller #(.COUNT_W(COUNT_W), .WAIT_LIMIT(WAIT_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .op_code(op_code), .zero_flag(zero_flag),
    .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .pc_en(pc_en), .state(state),
    .instr_count(instr_count), .halted(halted), .illegal_op(illegal_op),
    .mem_timeout(mem_timeout)
  );

  assign ctl = {mem_read, mem_write, iord, ir_write, reg_write, reg_dst, mem_to_reg,
                alu_src_a, alu_src_b, alu_op, pc_source, pc_en};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] exp_cnt = 0;

  // Reference control table, in the same bit order as ctl.
  function automatic logic [14:0] model_ctl(input logic [3:0] s, input logic rdy,
                                            input logic z);
    logic mr, mw, io, irw, rw, rd, m2r, sa, pe;
    logic [1:0] sb_, aop, pcs;
    {mr, mw, io, irw, rw, rd, m2r, sa, pe} = '0;
    sb_ = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (s)
      FETCH:     begin mr = 1'b1; sb_ = 2'b01; irw = rdy; pe = rdy; end
      DECODE:    sb_ = 2'b11;
      MEM_ADDR:  begin sa = 1'b1; sb_ = 2'b10; end
      MEM_READ:  begin mr = 1'b1; io = 1'b1; end
      MEM_WB:    begin rw = 1'b1; m2r = 1'b1; end
      MEM_WRITE: begin mw = 1'b1; io = 1'b1; end
      EXECUTE:   begin sa = 1'b1; aop = 2'b10; end
      R_WB:      begin rw = 1'b1; rd = 1'b1; end
      BRANCH:    begin sa = 1'b1; aop = 2'b01; pcs = 2'b01; pe = z; end
      default:   ;
    endcase
    return {mr, mw, io, irw, rw, rd, m2r, sa, sb_, aop, pcs, pe};
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_total++;
    if (sb.size() == 0) begin
      $error("FAIL scoreboard_empty: observed %0h required an expected entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_sc(input string tag, input logic [3:0] s);
    #1;
    push({tag, "_state"}, 32'(s));
    push({tag, "_ctl"}, 32'(model_ctl(s, mem_ready, zero_flag)));
    check(32'(state));
    check(32'(ctl));
  endtask

  task automatic expect_cnt(input string tag);
    push({tag, "_count"}, exp_cnt);
    check(instr_count);
  endtask

  task automatic expect_status(input string tag, input logic h, input logic ill,
                               input logic tmo);
    push({tag, "_halted"}, 32'(h));
    push({tag, "_illegal"}, 32'(ill));
    push({tag, "_timeout"}, 32'(tmo));
    check(32'(halted));
    check(32'(illegal_op));
    check(32'(mem_timeout));
  endtask

  // seq lists n states, first state in the most significant occupied nibble.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic z,
                           input int n, input logic [23:0] seq);
    op_code   = op;
    zero_flag = z;
    mem_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      expect_sc(tag, seq[4*(n-1-i) +: 4]);
      if (i < n - 1) tick();
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    exp_cnt = 0;
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    op_code   = 6'b000000;
    zero_flag = 1'b0;
    mem_ready = 1'b0;

    // Values while reset is held.
    #2;
    expect_sc("reset", FETCH);
    expect_cnt("reset");
    expect_status("reset", 1'b0, 1'b0, 1'b0);
    do_reset();

    // R-format add: 4 cycles.
    run_instr("add", 6'b000000, 1'b0, 5, {FETCH, DECODE, EXECUTE, R_WB, FETCH});
    exp_cnt++;
    expect_cnt("add");

    // lw: 5 cycles, sw: 4 cycles.
    run_instr("lw", 6'b100011, 1'b0, 6, {FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, FETCH});
    exp_cnt++;
    expect_cnt("lw");
    run_instr("sw", 6'b101011, 1'b0, 5, {FETCH, DECODE, MEM_ADDR, MEM_WRITE, FETCH});
    exp_cnt++;
    expect_cnt("sw");

    // beq taken and not taken: 3 cycles each.
    run_instr("beq_t", 6'b000100, 1'b1, 4, {FETCH, DECODE, BRANCH, FETCH});
    exp_cnt++;
    run_instr("beq_n", 6'b000100, 1'b0, 4, {FETCH, DECODE, BRANCH, FETCH});
    exp_cnt++;
    expect_cnt("beq");

    // FETCH stall of 3 cycles, then ready.
    op_code   = 6'b000000;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_sc("fstall", FETCH);
      tick();
    end
    mem_ready = 1'b1;
    expect_sc("fstall_done", FETCH);
    tick();
    expect_sc("fstall_dec", DECODE);
    repeat (3) tick();
    exp_cnt++;
    expect_sc("fstall_end", FETCH);
    expect_cnt("fstall");

    // Ready arriving on the cycle the wait counter sits at the limit completes normally.
    mem_ready = 1'b0;
    for (int i = 0; i < WAIT_LIMIT; i++) tick();
    expect_sc("limit_edge", FETCH);
    mem_ready = 1'b1;
    tick();
    expect_sc("limit_dec", DECODE);
    repeat (3) tick();
    exp_cnt++;
    expect_cnt("limit");

    // lw stuck in MEM_READ: WAIT_LIMIT stalled cycles allowed, HALT on the next one.
    op_code = 6'b100011;
    tick();
    tick();
    expect_sc("tmo_addr", MEM_ADDR);
    mem_ready = 1'b0;
    tick();
    expect_sc("tmo_read", MEM_READ);
    n = 0;
    while (state == MEM_READ && n < 40) begin
      n++;
      tick();
    end
    push("tmo_cycles", 32'(WAIT_LIMIT + 1));
    check(32'(n));
    expect_sc("tmo_halt", HALT);
    expect_status("tmo", 1'b1, 1'b0, 1'b1);
    expect_cnt("tmo");

    // Illegal opcode: HALT after DECODE, sticky through mem_ready toggling.
    do_reset();
    expect_status("post_reset", 1'b0, 1'b0, 1'b0);
    run_instr("ill", 6'b000010, 1'b0, 3, {FETCH, DECODE, HALT});
    expect_status("ill", 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      tick();
      expect_sc("ill_hold", HALT);
    end
    expect_status("ill_hold", 1'b1, 1'b1, 1'b0);
    expect_cnt("ill");

    // Reset asserted mid MEM_WRITE releases mem_write asynchronously.
    do_reset();
    op_code   = 6'b101011;
    mem_ready = 1'b1;
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    expect_sc("rstw_wait", MEM_WRITE);
    tick();
    expect_sc("rstw_wait2", MEM_WRITE);
    #2;
    rst_n = 1'b0;
    #1;
    push("rstw_mem_write", 32'(1'b0));
    check(32'(mem_write));
    push("rstw_state", 32'(FETCH));
    check(32'(state));
    expect_cnt("rstw");
    expect_status("rstw", 1'b0, 1'b0, 1'b0);
    #3;
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached with %0d/%0d checks passed",
             n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
